line_host_arb: RTL and testbench

Two-port cache-line arbiter and serializer in front of the DRAM controller's host port. It accepts 128-bit line read/write requests from the core's cache-fill port (port A) and from a second line master such as DMA or the debug loader (port B). It grants one owner at a time round-robin, issues a single 8-beat burst per line on the 16-bit host interface, and returns a one-cycle finish pulse with the assembled line. It sits between `mp_core`/DMA and `ram_core`, replacing the direct tie-off of the host port.

---
 rtl/line_host_arb.sv | 150 +++++++++++++++
 tb/tb_line_host_arb.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_host_arb.sv
// Two-port round-robin cache-line arbiter that serializes each 128-bit line
// into one 8-beat, 16-bit burst on the DRAM controller host port.
module line_host_arb #(
    parameter logic [31:0] HOST_BASE = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         a_req,
    input  logic         a_rwn,
    input  logic [15:0]  a_addr,
    input  logic [127:0] a_wdata,
    output logic         a_finish,
    input  logic         b_req,
    input  logic         b_rwn,
    input  logic [15:0]  b_addr,
    input  logic [127:0] b_wdata,
    output logic         b_finish,
    output logic [127:0] rdata,
    output logic [1:0]   grant,
    output logic         host_req,
    output logic         host_rwn,
    output logic         host_burst,
    output logic [31:0]  host_addr,
    input  logic         host_ack,
    output logic [1:0]   host_txm,
    output logic [15:0]  host_txd,
    input  logic         host_txd_ack,
    input  logic [15:0]  host_rxd,
    input  logic         host_rxd_vld
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_WDATA,
        S_RDATA,
        S_DONE
    } state_t;

    state_t       state_q, state_d;
    logic [2:0]   cnt_q, cnt_d;
    logic [127:0] buf_q, buf_d;
    logic [127:0] rdata_q, rdata_d;
    logic [11:0]  addr_q, addr_d;
    logic         rwn_q, rwn_d;
    logic         own_q, own_d;
    logic         last_q, last_d;
    logic         cool_q, cool_d;
    logic         beat;
    logic         last_beat;
    logic         pick_b;
    logic         unused_addr_bits;

    assign unused_addr_bits = ^{a_addr[3:0], b_addr[3:0]};

    // last_q = 1 means B owned the previous line, so A wins a tie
    assign pick_b    = b_req & (~a_req | ~last_q);
    assign beat      = rwn_q ? host_rxd_vld : host_txd_ack;
    assign last_beat = beat & (cnt_q == 3'd7);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        rdata_d = rdata_q;
        addr_d  = addr_q;
        rwn_d   = rwn_q;
        own_d   = own_q;
        last_d  = last_q;
        cool_d  = cool_q;
        unique case (state_q)
            S_IDLE: begin
                if (cool_q) begin
                    cool_d = 1'b0;
                end else if (a_req | b_req) begin
                    own_d   = pick_b;
                    rwn_d   = pick_b ? b_rwn : a_rwn;
                    addr_d  = pick_b ? b_addr[15:4] : a_addr[15:4];
                    buf_d   = pick_b ? b_wdata : a_wdata;
                    cnt_d   = 3'd0;
                    state_d = S_CMD;
                end
            end
            S_CMD, S_WDATA, S_RDATA: begin
                if (beat) begin
                    cnt_d = cnt_q + 3'd1;
                    if (rwn_q) begin
                        buf_d[{cnt_q, 4'b0000} +: 16] = host_rxd;
                    end
                end
                if (state_q == S_CMD) begin
                    if (host_ack) begin
                        if (last_beat) state_d = S_DONE;
                        else state_d = rwn_q ? S_RDATA : S_WDATA;
                    end
                end else if (last_beat) begin
                    state_d = S_DONE;
                end
                // publish the line only once all eight beats are in
                if (state_d == S_DONE && rwn_q) begin
                    rdata_d = buf_d;
                end
            end
            S_DONE: begin
                last_d  = own_q;
                cool_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            buf_q   <= '0;
            rdata_q <= '0;
            addr_q  <= '0;
            rwn_q   <= 1'b1;
            own_q   <= 1'b0;
            last_q  <= 1'b1;
            cool_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
            rwn_q   <= rwn_d;
            own_q   <= own_d;
            last_q  <= last_d;
            cool_q  <= cool_d;
        end
    end

    assign host_req   = (state_q == S_CMD);
    assign host_rwn   = rwn_q;
    assign host_burst = 1'b1;
    assign host_addr  = {HOST_BASE[31:16], addr_q, 4'b0000};
    assign host_txm   = 2'b00;
    assign host_txd   = buf_q[{cnt_q, 4'b0000} +: 16];
    assign a_finish   = (state_q == S_DONE) & ~own_q;
    assign b_finish   = (state_q == S_DONE) & own_q;
    assign grant      = (state_q == S_IDLE) ? 2'b00 : {own_q, ~own_q};
    assign rdata      = rdata_q;

endmodule

// File: tb/tb_line_host_arb.sv
// Self-checking bench for line_host_arb: directed vector table, hand-built
// contention/reset/spurious sequences and randomized line traffic.
module tb_line_host_arb;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         a_req, a_rwn, b_req, b_rwn;
    logic [15:0]  a_addr, b_addr;
    logic [127:0] a_wdata, b_wdata;
    logic         a_finish, b_finish;
    logic [127:0] rdata;
    logic [1:0]   grant;
    logic         host_req, host_rwn, host_burst;
    logic [31:0]  host_addr;
    logic         host_ack;
    logic [1:0]   host_txm;
    logic [15:0]  host_txd;
    logic         host_txd_ack;
    logic [15:0]  host_rxd;
    logic         host_rxd_vld;

    int           errors = 0;
    int           checks = 0;
    logic [127:0] exp_rd;
    int           last_p;

    always #5 clk = ~clk;

    line_host_arb dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_rwn(a_rwn), .a_addr(a_addr),
        .a_wdata(a_wdata), .a_finish(a_finish),
        .b_req(b_req), .b_rwn(b_rwn), .b_addr(b_addr),
        .b_wdata(b_wdata), .b_finish(b_finish),
        .rdata(rdata), .grant(grant),
        .host_req(host_req), .host_rwn(host_rwn),
        .host_burst(host_burst), .host_addr(host_addr),
        .host_ack(host_ack), .host_txm(host_txm),
        .host_txd(host_txd), .host_txd_ack(host_txd_ack),
        .host_rxd(host_rxd), .host_rxd_vld(host_rxd_vld)
    );

    typedef struct {
        int           p;
        bit           rwn;
        logic [15:0]  addr;
        logic [127:0] wd;
        logic [15:0]  rb;
        int           ackdly;
        int           stall;
        bit           ovl;
        logic [31:0]  exp_haddr;
    } vec_t;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chk_rst(input string nm);
        chk({nm, "_grant"}, grant, 0);
        chk({nm, "_req"}, host_req, 0);
        chk({nm, "_rwn_burst_txm"}, {host_rwn, host_burst, host_txm}, 4'b1100);
        chk({nm, "_addr"}, host_addr, 0);
        chk({nm, "_txd"}, host_txd, 0);
        chk({nm, "_fin"}, {b_finish, a_finish}, 0);
        chk({nm, "_rdata"}, rdata, 0);
    endtask

    // Plays the host side of one line for owner p; request is already raised.
    task automatic xfer(input int p, input bit rwn, input logic [127:0] wd,
                        input logic [15:0] rb, input int ackdly,
                        input int stall, input bit ovl,
                        input logic [31:0] xa);
        logic [127:0] rl;
        int k;
        int c;
        bit go;
        for (int i = 0; i < 8; i++) rl[16*i +: 16] = rb + 16'(i);
        @(negedge clk);
        chk("grant", grant, (p == 1) ? 2'b10 : 2'b01);
        chk("host_req", host_req, 1);
        chk("host_rwn", host_rwn, rwn);
        chk("host_addr", host_addr, xa);
        chk("burst_txm", {host_burst, host_txm}, 3'b100);
        if (!rwn) chk("txd_first", host_txd, wd[15:0]);
        for (int d = 0; d < ackdly; d++) begin
            @(negedge clk);
            chk("req_hold", host_req, 1);
        end
        host_ack = 1'b1;
        k = 0;
        c = 0;
        while (k < 8) begin
            if (c == 0) go = ovl;
            else if (stall == 0) go = 1'b1;
            else if (stall == 1) go = c[0];
            else go = 1'($urandom_range(0, 1));
            host_txd_ack = 1'b0;
            host_rxd_vld = 1'b0;
            host_rxd = 16'($urandom);
            if (rwn) begin
                host_txd_ack = 1'($urandom_range(0, 1));
                if (go) begin
                    host_rxd_vld = 1'b1;
                    host_rxd = rl[16*k +: 16];
                end
            end else begin
                host_rxd_vld = 1'($urandom_range(0, 1));
                chk("txd_beat", host_txd, wd[16*k +: 16]);
                host_txd_ack = go;
            end
            if (p == 1) begin
                b_wdata = {4{$urandom}};
                b_addr = 16'($urandom);
            end else begin
                a_wdata = {4{$urandom}};
                a_addr = 16'($urandom);
            end
            if (go) k++;
            @(negedge clk);
            host_ack = 1'b0;
            if (c == 0) chk("req_drop", host_req, 0);
            c++;
            if (k < 8) chk("no_early_fin", {b_finish, a_finish}, 0);
        end
        host_txd_ack = 1'b0;
        host_rxd_vld = 1'b0;
        chk("finish", {b_finish, a_finish}, (p == 1) ? 2'b10 : 2'b01);
        if (rwn) exp_rd = rl;
        chk("rdata", rdata, exp_rd);
        @(negedge clk);
        chk("fin_pulse", {b_finish, a_finish}, 0);
        chk("cool_grant", grant, 0);
        @(negedge clk);
        chk("no_regrant", grant, 0);
        chk("idle_req", host_req, 0);
        if (p == 1) b_req = 1'b0;
        else a_req = 1'b0;
        last_p = p;
    endtask

    task automatic raise(input int p, input bit rwn, input logic [15:0] addr,
                         input logic [127:0] wd);
        if (p == 1) begin
            b_rwn = rwn; b_addr = addr; b_wdata = wd; b_req = 1'b1;
        end else begin
            a_rwn = rwn; a_addr = addr; a_wdata = wd; a_req = 1'b1;
        end
    endtask

    vec_t         vecs[5];
    bit           prw[2];
    logic [15:0]  pad[2];
    logic [127:0] pwd[2];
    logic [15:0]  prb[2];
    int           mask;
    int           p;

    initial begin
        vecs[0] = '{0, 1'b1, 16'h1230, 128'h0, 16'h0100, 3, 0, 1'b0,
                    32'h0000_1230};
        vecs[1] = '{1, 1'b0, 16'h4560,
                    128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100,
                    16'h0, 1, 1, 1'b0, 32'h0000_4560};
        vecs[2] = '{0, 1'b1, 16'hFFFF, 128'h0, 16'hA000, 0, 0, 1'b1,
                    32'h0000_FFF0};
        vecs[3] = '{1, 1'b1, 16'h0008, 128'h0, 16'h5550, 2, 2, 1'b1,
                    32'h0000_0000};
        vecs[4] = '{0, 1'b0, 16'h7777,
                    128'hDEAD_BEEF_0123_4567_89AB_CDEF_5A5A_A5A5,
                    16'h0, 0, 0, 1'b1, 32'h0000_7770};

        rst_n = 1'b0;
        a_req = 0; a_rwn = 1; a_addr = 0; a_wdata = 0;
        b_req = 0; b_rwn = 1; b_addr = 0; b_wdata = 0;
        host_ack = 0; host_txd_ack = 0; host_rxd = 0; host_rxd_vld = 0;
        exp_rd = '0;
        last_p = 1;
        repeat (2) @(negedge clk);
        chk_rst("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // contention: both ports raise together, twice -> A, B, A, B
        for (int r = 0; r < 2; r++) begin
            logic [127:0] wb;
            wb = {4{$urandom}};
            raise(0, 1'b1, 16'h3000 + 16'(r * 16), 128'h0);
            raise(1, 1'b0, 16'h4000, wb);
            xfer(0, 1'b1, 128'h0, 16'h1100 + 16'(r * 256), r, 0, 1'b0,
                 32'h0000_3000 + 32'(r * 16));
            xfer(1, 1'b0, wb, 16'h0, 1, 2, 1'b0, 32'h0000_4000);
        end

        for (int i = 0; i < 5; i++) begin
            raise(vecs[i].p, vecs[i].rwn, vecs[i].addr, vecs[i].wd);
            xfer(vecs[i].p, vecs[i].rwn, vecs[i].wd, vecs[i].rb,
                 vecs[i].ackdly, vecs[i].stall, vecs[i].ovl,
                 vecs[i].exp_haddr);
            if (i == 0)
                chk("single_read_line", rdata,
                    128'h0107_0106_0105_0104_0103_0102_0101_0100);
        end

        // stray beat strobes while idle must not start anything
        for (int i = 0; i < 3; i++) begin
            host_txd_ack = 1'b1;
            host_rxd_vld = 1'b1;
            @(negedge clk);
            chk("spur_grant", grant, 0);
            chk("spur_req", host_req, 0);
            chk("spur_fin", {b_finish, a_finish}, 0);
        end
        host_txd_ack = 1'b0;
        host_rxd_vld = 1'b0;
        raise(1, 1'b0, 16'h9990, 128'h1111_2222_3333_4444_5555_6666_7777_8888);
        xfer(1, 1'b0, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 16'h0,
             0, 0, 1'b1, 32'h0000_9990);

        // reset in the middle of a read burst
        raise(0, 1'b1, 16'h2220, 128'h0);
        @(negedge clk);
        chk("mid_grant", grant, 2'b01);
        host_ack = 1'b1;
        @(negedge clk);
        host_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            host_rxd_vld = 1'b1;
            host_rxd = 16'hBEE0 + 16'(i);
            @(negedge clk);
        end
        host_rxd_vld = 1'b0;
        a_req = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_rst("mid_rst");
        @(negedge clk);
        chk_rst("in_rst");
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk_rst("post_rst");
        end
        exp_rd = '0;
        last_p = 1;
        raise(0, 1'b1, 16'h2220, 128'h0);
        xfer(0, 1'b1, 128'h0, 16'hC000, 1, 0, 1'b0, 32'h0000_2220);

        // randomized traffic against the round-robin model
        for (int it = 0; it < 24; it++) begin
            mask = $urandom_range(1, 3);
            for (int q = 0; q < 2; q++) begin
                prw[q] = 1'($urandom_range(0, 1));
                pad[q] = 16'($urandom);
                pwd[q] = {4{$urandom}};
                prb[q] = 16'($urandom);
                if (mask[q]) raise(q, prw[q], pad[q], pwd[q]);
            end
            while (mask != 0) begin
                if (mask == 3) p = (last_p == 1) ? 0 : 1;
                else p = (mask == 2) ? 1 : 0;
                xfer(p, prw[p], pwd[p], prb[p], $urandom_range(0, 3),
                     $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                     {16'h0, pad[p][15:4], 4'h0});
                mask = mask & ~(1 << p);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no end want finish");
        $fatal(1);
    end

endmodule
